top_udiv_92ns_64ns_28_seq: RTL and testbench

Sequential unsigned divider that inverts the 28×64→92 product path: it takes a 92-bit dividend and a 64-bit divisor and returns a 28-bit quotient and a 64-bit remainder. It sits beside the combinational multiplier in the generated datapath and recovers the 28-bit operand from a product when the 64-bit operand is known. It is a radix-2 restoring divider with valid/ready handshakes on both sides and one operation in flight.

---
 rtl/top_udiv_92ns_64ns_28_seq.sv | 160 ++++++++++++++++
 tb/tb_top_udiv_92ns_64ns_28_seq.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/top_udiv_92ns_64ns_28_seq.sv
// Sequential radix-2 restoring divider: 92-bit dividend / 64-bit divisor -> 28-bit quotient, 64-bit remainder.
// Single operation in flight, valid/ready handshakes on both sides.
module top_udiv_92ns_64ns_28_seq #(
    parameter int din0_WIDTH = 92,
    parameter int din1_WIDTH = 64,
    parameter int dout_WIDTH = 28
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [dout_WIDTH-1:0] quot,
    output logic [din1_WIDTH-1:0] rem,
    output logic                  ovf,
    output logic                  dbz
);

    localparam int CW = $clog2(dout_WIDTH + 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t                state_q, state_d;
    logic [din1_WIDTH-1:0] d_q, d_d;
    logic [din1_WIDTH-1:0] r_q, r_d;
    logic [dout_WIDTH-1:0] q_q, q_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [dout_WIDTH-1:0] quot_q, quot_d;
    logic [din1_WIDTH-1:0] rem_q, rem_d;
    logic                  ovf_q, ovf_d;
    logic                  dbz_q, dbz_d;

    logic                  accept;
    logic                  last;
    logic [din1_WIDTH-1:0] hi;
    logic [dout_WIDTH-1:0] lo;
    logic [din1_WIDTH:0]   t;
    logic                  ge;
    logic [din1_WIDTH-1:0] r_nxt;
    logic [dout_WIDTH-1:0] q_nxt;

    assign hi     = din0[dout_WIDTH +: din1_WIDTH];
    assign lo     = din0[dout_WIDTH-1:0];
    assign accept = in_valid && in_ready;
    assign last   = (cnt_q == CW'(dout_WIDTH - 1));

    // R < D always holds, so the low-bit difference is exact and the carry-out can be dropped.
    assign t     = {r_q, q_q[dout_WIDTH-1]};
    assign ge    = (t >= {1'b0, d_q});
    assign r_nxt = ge ? (t[din1_WIDTH-1:0] - d_q) : t[din1_WIDTH-1:0];
    assign q_nxt = {q_q[dout_WIDTH-2:0], ge};

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if ((din1 == '0) || (hi >= din1)) state_d = DONE;
                    else                              state_d = CALC;
                end
            end
            CALC: begin
                if (last) state_d = DONE;
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE) && !ap_rst;
        out_valid = (state_q == DONE);
    end

    always_comb begin
        d_d    = d_q;
        r_d    = r_q;
        q_d    = q_q;
        cnt_d  = cnt_q;
        quot_d = quot_q;
        rem_d  = rem_q;
        ovf_d  = ovf_q;
        dbz_d  = dbz_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    d_d   = din1;
                    r_d   = hi;
                    q_d   = lo;
                    cnt_d = '0;
                    if (din1 == '0) begin
                        dbz_d  = 1'b1;
                        ovf_d  = 1'b0;
                        quot_d = '1;
                        rem_d  = '0;
                    end else if (hi >= din1) begin
                        dbz_d  = 1'b0;
                        ovf_d  = 1'b1;
                        quot_d = '1;
                        rem_d  = '0;
                    end else begin
                        dbz_d  = 1'b0;
                        ovf_d  = 1'b0;
                    end
                end
            end
            CALC: begin
                r_d   = r_nxt;
                q_d   = q_nxt;
                cnt_d = cnt_q + CW'(1);
                if (last) begin
                    quot_d = q_nxt;
                    rem_d  = r_nxt;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            d_q    <= '0;
            r_q    <= '0;
            q_q    <= '0;
            cnt_q  <= '0;
            quot_q <= '0;
            rem_q  <= '0;
            ovf_q  <= 1'b0;
            dbz_q  <= 1'b0;
        end else begin
            d_q    <= d_d;
            r_q    <= r_d;
            q_q    <= q_d;
            cnt_q  <= cnt_d;
            quot_q <= quot_d;
            rem_q  <= rem_d;
            ovf_q  <= ovf_d;
            dbz_q  <= dbz_d;
        end
    end

    assign quot = quot_q;
    assign rem  = rem_q;
    assign ovf  = ovf_q;
    assign dbz  = dbz_q;

endmodule

// File: tb/tb_top_udiv_92ns_64ns_28_seq.sv
// Directed self-checking bench for the sequential 92/64 divider.
module tb_top_udiv_92ns_64ns_28_seq;

    logic        ap_clk = 1'b0;
    logic        ap_rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [91:0] din0 = '0;
    logic [63:0] din1 = '0;
    logic        in_ready;
    logic        out_valid;
    logic [27:0] quot;
    logic [63:0] rem;
    logic        ovf;
    logic        dbz;

    int total = 0;
    int bad   = 0;

    top_udiv_92ns_64ns_28_seq #(
        .din0_WIDTH(92),
        .din1_WIDTH(64),
        .dout_WIDTH(28)
    ) dut (
        .ap_clk   (ap_clk),
        .ap_rst   (ap_rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .din0     (din0),
        .din1     (din1),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .quot     (quot),
        .rem      (rem),
        .ovf      (ovf),
        .dbz      (dbz)
    );

    always #5 ap_clk = ~ap_clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge ap_clk);
        #1;
    endtask

    // lat counts rising edges from the accept edge (inclusive) until out_valid is seen.
    task automatic run_op(input string tag, input logic [91:0] a, input logic [63:0] b, output int lat);
        check({tag, "_rdy_pre"}, in_ready, 1);
        in_valid = 1'b1;
        din0     = a;
        din1     = b;
        tick;
        in_valid = 1'b0;
        lat      = 1;
        while (!out_valid && lat < 100) begin
            tick;
            lat++;
        end
    endtask

    task automatic release_result(input string tag);
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
        check({tag, "_rdy_post"}, in_ready, 1);
        check({tag, "_ov_post"}, out_valid, 0);
    endtask

    task automatic verify(input string tag, input logic [91:0] a, input logic [63:0] b,
                          input logic [27:0] eq, input logic [63:0] er,
                          input logic eo, input logic ez, input int elat);
        int lat;
        run_op(tag, a, b, lat);
        check({tag, "_lat"}, lat, elat);
        check({tag, "_quot"}, quot, eq);
        check({tag, "_rem"}, rem, er);
        check({tag, "_ovf"}, ovf, eo);
        check({tag, "_dbz"}, dbz, ez);
        release_result(tag);
    endtask

    initial begin
        int          lat;
        bit          seen;
        logic [27:0] hq;
        logic [63:0] hr;

        ap_rst = 1'b1;
        repeat (3) @(posedge ap_clk);
        #1;
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_quot", quot, 0);
        check("rst_rem", rem, 0);
        check("rst_ovf", ovf, 0);
        check("rst_dbz", dbz, 0);
        ap_rst = 1'b0;
        #1;
        check("rel_in_ready", in_ready, 1);
        tick;

        verify("basic", 92'd100, 64'd7, 28'd14, 64'd2, 1'b0, 1'b0, 29);
        verify("maxq", 92'hFFFFFFFFFFFFFFF_E_FFFFFFF, 64'hFFFFFFFFFFFFFFFF,
               28'hFFFFFFF, 64'hFFFFFFFFFFFFFFFE, 1'b0, 1'b0, 29);
        verify("dbz", 92'd12345, 64'd0, 28'hFFFFFFF, 64'd0, 1'b0, 1'b1, 1);
        verify("ovf_max", {92{1'b1}}, 64'd1, 28'hFFFFFFF, 64'd0, 1'b1, 1'b0, 1);
        verify("ovf_eq", 92'd5 << 28, 64'd5, 28'hFFFFFFF, 64'd0, 1'b1, 1'b0, 1);
        verify("small", 92'd1000, 64'd3, 28'd333, 64'd1, 1'b0, 1'b0, 29);

        // Backpressure: result must hold while operands and in_valid churn.
        run_op("bp", 92'd1000, 64'd7, lat);
        check("bp_lat", lat, 29);
        hq = quot;
        hr = rem;
        check("bp_quot0", hq, 28'd142);
        check("bp_rem0", hr, 64'd6);
        for (int i = 0; i < 10; i++) begin
            in_valid = ~in_valid;
            din0     = {$urandom(), $urandom(), $urandom()};
            din1     = {$urandom(), $urandom()};
            tick;
            check("bp_hold_quot", quot, 28'd142);
            check("bp_hold_rem", rem, 64'd6);
            check("bp_hold_ov", out_valid, 1);
            check("bp_hold_rdy", in_ready, 0);
            check("bp_hold_flags", {ovf, dbz}, 2'b00);
        end
        in_valid = 1'b0;
        release_result("bp");
        verify("bp_next", 92'd81, 64'd9, 28'd9, 64'd0, 1'b0, 1'b0, 29);

        // Asynchronous reset in the middle of a CALC sequence.
        in_valid = 1'b1;
        din0     = 92'd100;
        din1     = 64'd7;
        tick;
        in_valid = 1'b0;
        repeat (10) tick;
        #2;
        ap_rst = 1'b1;
        #1;
        check("mid_rst_ov", out_valid, 0);
        check("mid_rst_quot", quot, 0);
        check("mid_rst_rem", rem, 0);
        check("mid_rst_flags", {ovf, dbz}, 2'b00);
        check("mid_rst_rdy", in_ready, 0);
        @(posedge ap_clk);
        #1;
        ap_rst = 1'b0;
        #1;
        check("mid_rel_rdy", in_ready, 1);
        seen = 1'b0;
        repeat (40) begin
            tick;
            if (out_valid) seen = 1'b1;
        end
        check("mid_no_stale", seen, 0);
        verify("pow2", 92'd1 << 40, 64'd1 << 20, 28'd1 << 20, 64'd0, 1'b0, 1'b0, 29);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
